// File: rtl/difftest_irp_pkg.sv
// difftest_irp_pkg: shared types and helpers for the multi-core interrupt-pending event queue
package difftest_irp_pkg;
    localparam int IRP_W = 10;
    localparam int IRP_MEIP = 0;
    localparam int IRP_MTIP = 1;
    localparam int IRP_MSIP = 2;
    localparam int IRP_SEIP = 3;
    localparam int IRP_STIP = 4;
    localparam int IRP_VSEIP = 5;
    localparam int IRP_VSTIP = 6;
    localparam int IRP_AIA_MEIP = 7;
    localparam int IRP_AIA_SEIP = 8;
    localparam int IRP_LCOFI = 9;
    localparam int MAX_CORES = 16;
    localparam int SEQ_MAX_W = 32;

    typedef struct packed {
        logic [7:0] coreid;
        logic [IRP_W-1:0] irp;
        logic [SEQ_MAX_W-1:0] seq;
    } irp_event_t;

    // first set request at or after ptr, wrapping modulo n; ptr when none is set
    function automatic logic [3:0] rrNext(input logic [MAX_CORES-1:0] req, input logic [3:0] ptr, input int n);
        logic [3:0] r;
        logic [3:0] idx;
        r = ptr;
        for (int k = MAX_CORES - 1; k >= 0; k--) begin
            idx = 4'((int'(ptr) + k) % n);
            if (k < n && req[idx]) r = idx;
        end
        return r;
    endfunction
endpackage

// File: rtl/difftest_irp_event_queue_if.sv
// difftest_irp_event_queue_if: tagged event stream toward the difftest DPI bridge
interface difftest_irp_event_queue_if #(parameter int SEQ_W = 16);
    import difftest_irp_pkg::*;
    logic out_valid;
    logic out_ready;
    logic [IRP_W-1:0] out_irp;
    logic [7:0] out_coreid;
    logic [SEQ_W-1:0] out_seq;
    modport master(output out_valid, out_irp, out_coreid, out_seq, input out_ready);
    modport slave(input out_valid, out_irp, out_coreid, out_seq, output out_ready);
endinterface

// File: rtl/difftest_sync_fifo.sv
// difftest_sync_fifo: show-ahead synchronous FIFO with occupancy output; head reads as zero when empty
module difftest_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic [WIDTH-1:0] pushData,
    input  logic pop,
    output logic [WIDTH-1:0] popData,
    output logic empty,
    output logic full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic doPush, doPop;

    always_comb begin
        empty = level == '0;
        full = level == (AW+1)'(DEPTH);
        doPop = pop && !empty;
        doPush = push && (!full || doPop);
        popData = empty ? '0 : mem[rdPtr];
    end

    always_ff @(posedge clock)
        if (doPush) mem[wrPtr] <= pushData;

    always_ff @(posedge clock)
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            wrPtr <= wrPtr + AW'(doPush);
            rdPtr <= rdPtr + AW'(doPop);
            level <= level + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
endmodule

// File: rtl/difftest_irp_event_queue.sv
// difftest_irp_event_queue: per-core interrupt-pending change capture with coalescing,
// round-robin arbitration and a buffered tagged output stream
module difftest_irp_event_queue
    import difftest_irp_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16,
    parameter int DELTA_ONLY = 1,
    parameter int CORE_ID_BASE = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic [NUM_CORES-1:0] in_valid,
    input  logic [NUM_CORES*IRP_W-1:0] in_irp,
    difftest_irp_event_queue_if.master eventOut,
    output logic [15:0] coalesce_cnt,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int EW = 8 + IRP_W + SEQ_W;
    logic [IRP_W-1:0] lastIrp [NUM_CORES];
    logic [IRP_W-1:0] slot [NUM_CORES];
    logic [IRP_W-1:0] grantSlot;
    logic [NUM_CORES-1:0] pending, capture, coalesce;
    logic [3:0] rrPtr, grantIdx;
    logic grant, pop, full, empty;
    logic [SEQ_W-1:0] seq;
    logic [EW-1:0] head;
    logic [4:0] coalesceInc;
    logic [16:0] coalesceSum;

    always_comb begin
        capture = '0;
        coalesce = '0;
        coalesceInc = '0;
        grantSlot = '0;
        pop = eventOut.out_valid && eventOut.out_ready;
        grantIdx = rrNext(MAX_CORES'(pending), rrPtr, NUM_CORES);
        grant = |pending && (!full || pop);
        for (int i = 0; i < NUM_CORES; i++) begin
            capture[i] = enable && in_valid[i] && (DELTA_ONLY == 0 || in_irp[i*IRP_W +: IRP_W] != lastIrp[i]);
            // a granted channel refills its slot from the new sample instead of merging
            coalesce[i] = capture[i] && pending[i] && !(grant && grantIdx == 4'(i));
            coalesceInc = coalesceInc + 5'(coalesce[i]);
            grantSlot = grantIdx == 4'(i) ? slot[i] : grantSlot;
        end
        coalesceSum = {1'b0, coalesce_cnt} + 17'(coalesceInc);
    end

    difftest_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) fifo (
        .clock,
        .reset,
        .push(grant),
        .pushData({8'(CORE_ID_BASE + int'(grantIdx)), grantSlot, seq}),
        .pop,
        .popData(head),
        .empty,
        .full,
        .level(fifo_level)
    );

    assign eventOut.out_valid = !empty;
    assign {eventOut.out_coreid, eventOut.out_irp, eventOut.out_seq} = head;

    always_ff @(posedge clock)
        if (reset) begin
            pending <= '0;
            rrPtr <= '0;
            seq <= '0;
            coalesce_cnt <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                lastIrp[i] <= '0;
                slot[i] <= '0;
            end
        end else begin
            if (grant) begin
                seq <= seq + SEQ_W'(1);
                rrPtr <= grantIdx == 4'(NUM_CORES - 1) ? '0 : grantIdx + 4'd1;
            end
            coalesce_cnt <= coalesceSum[16] ? 16'hFFFF : coalesceSum[15:0];
            for (int i = 0; i < NUM_CORES; i++)
                if (capture[i]) begin
                    lastIrp[i] <= in_irp[i*IRP_W +: IRP_W];
                    slot[i] <= in_irp[i*IRP_W +: IRP_W];
                    pending[i] <= 1'b1;
                end else if (grant && grantIdx == 4'(i)) begin
                    pending[i] <= 1'b0;
                end
        end
endmodule

// File: tb/tb_difftest_irp_event_queue.sv
// tb_difftest_irp_event_queue: directed scenarios plus randomized traffic against a queue-based reference model
module tb_difftest_irp_event_queue;
    import difftest_irp_pkg::*;
    localparam int NC = 2;

    logic clock = 0, reset = 1, enable = 1, out_ready = 0;
    logic [NC-1:0] in_valid = '0;
    logic [NC*IRP_W-1:0] in_irp = '0;
    logic [15:0] coal0, coal1;
    logic [2:0] lvl0;
    logic [3:0] lvl1;
    int compared = 0, mismatched = 0;
    bit chkOn = 0;

    difftest_irp_event_queue_if #(.SEQ_W(16)) bus0();
    difftest_irp_event_queue_if #(.SEQ_W(16)) bus1();
    assign bus0.out_ready = out_ready;
    assign bus1.out_ready = out_ready;

    always #5 clock = ~clock;

    difftest_irp_event_queue #(.NUM_CORES(NC), .DEPTH(4), .SEQ_W(16), .DELTA_ONLY(1), .CORE_ID_BASE(0)) dut0 (
        .clock, .reset, .enable, .in_valid, .in_irp, .eventOut(bus0), .coalesce_cnt(coal0), .fifo_level(lvl0));
    difftest_irp_event_queue #(.NUM_CORES(NC), .DEPTH(8), .SEQ_W(16), .DELTA_ONLY(0), .CORE_ID_BASE(5)) dut1 (
        .clock, .reset, .enable, .in_valid, .in_irp, .eventOut(bus1), .coalesce_cnt(coal1), .fifo_level(lvl1));

    logic dValid [2];
    logic [9:0] dIrp [2];
    logic [7:0] dCore [2];
    logic [15:0] dSeq [2];
    logic [15:0] dCoal [2];
    logic [7:0] dLvl [2];
    assign dValid[0] = bus0.out_valid;
    assign dValid[1] = bus1.out_valid;
    assign dIrp[0] = bus0.out_irp;
    assign dIrp[1] = bus1.out_irp;
    assign dCore[0] = bus0.out_coreid;
    assign dCore[1] = bus1.out_coreid;
    assign dSeq[0] = bus0.out_seq;
    assign dSeq[1] = bus1.out_seq;
    assign dCoal[0] = coal0;
    assign dCoal[1] = coal1;
    assign dLvl[0] = 8'(lvl0);
    assign dLvl[1] = 8'(lvl1);

    // reference model: per-instance parameters, pending slots and an event queue
    int mDepth [2] = '{4, 8};
    bit mDelta [2] = '{1, 0};
    int mBase [2] = '{0, 5};
    logic [9:0] mLast [2][NC];
    logic [9:0] mSlot [2][NC];
    bit mPend [2][NC];
    int mRr [2], mSeq [2], mCoal [2];
    bit mEver [2];
    irp_event_t mQ [2][$];
    irp_event_t capQ [2][$];

    logic sReset, sEnable, sReady;
    logic [NC-1:0] sValid;
    logic [NC*IRP_W-1:0] sIrp;
    always @(posedge clock) begin
        sReset <= reset;
        sEnable <= enable;
        sValid <= in_valid;
        sIrp <= in_irp;
        sReady <= out_ready;
    end

    always @(negedge clock) begin
        bit cap [NC];
        bit pop, eV;
        int g, idx;
        irp_event_t h;
        logic [24:0] gotA, expA;
        logic [33:0] gotB, expB;
        for (int d = 0; d < 2; d++) begin
            if (sReset) begin
                mQ[d].delete();
                mRr[d] = 0; mSeq[d] = 0; mCoal[d] = 0; mEver[d] = 0;
                for (int i = 0; i < NC; i++) begin
                    mLast[d][i] = 0; mSlot[d][i] = 0; mPend[d][i] = 0;
                end
            end else begin
                for (int i = 0; i < NC; i++)
                    cap[i] = sEnable && sValid[i] && (!mDelta[d] || sIrp[i*10 +: 10] != mLast[d][i]);
                pop = mQ[d].size() > 0 && sReady;
                g = -1;
                if (mQ[d].size() < mDepth[d] || pop)
                    for (int k = 0; k < NC; k++) begin
                        idx = (mRr[d] + k) % NC;
                        if (g < 0 && mPend[d][idx]) g = idx;
                    end
                if (pop) void'(mQ[d].pop_front());
                if (g >= 0) begin
                    mQ[d].push_back({8'(mBase[d] + g), mSlot[d][g], 32'(mSeq[d])});
                    mSeq[d] = (mSeq[d] + 1) % 65536;
                    mRr[d] = (g + 1) % NC;
                    mEver[d] = 1;
                end
                for (int i = 0; i < NC; i++)
                    if (cap[i]) begin
                        if (mPend[d][i] && i != g) mCoal[d] = mCoal[d] < 65535 ? mCoal[d] + 1 : 65535;
                        mPend[d][i] = 1;
                        mSlot[d][i] = sIrp[i*10 +: 10];
                        mLast[d][i] = sIrp[i*10 +: 10];
                    end else if (i == g) begin
                        mPend[d][i] = 0;
                    end
            end
            if (chkOn) begin
                eV = mQ[d].size() > 0;
                expA = {eV, 8'(mQ[d].size()), 16'(mCoal[d])};
                gotA = {dValid[d], dLvl[d], dCoal[d]};
                compared++;
                if (gotA !== expA) begin
                    mismatched++;
                    $display("FAIL status inst%0d t=%0t: got valid/level/coal %h required %h", d, $time, gotA, expA);
                end
                if (eV || !mEver[d]) begin
                    h = '0;
                    if (eV) h = mQ[d][0];
                    expB = {h.irp, h.coreid, h.seq[15:0]};
                    gotB = {dIrp[d], dCore[d], dSeq[d]};
                    compared++;
                    if (gotB !== expB) begin
                        mismatched++;
                        $display("FAIL head inst%0d t=%0t: got irp/core/seq %h required %h", d, $time, gotB, expB);
                    end
                end
            end
            if (dValid[d] && out_ready) capQ[d].push_back({dCore[d], dIrp[d], 32'(dSeq[d])});
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1;
        in_valid = '0;
        enable = 1;
        tick();
        tick();
        reset = 0;
        capQ[0].delete();
        capQ[1].delete();
    endtask

    task automatic test_reset();
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            compared++;
            if ({dValid[d], dIrp[d], dCore[d], dSeq[d], dLvl[d], dCoal[d]} !== 59'd0) begin
                mismatched++;
                $display("FAIL reset_state inst%0d: got %h required 0", d,
                         {dValid[d], dIrp[d], dCore[d], dSeq[d], dLvl[d], dCoal[d]});
            end
        end
        reset = 0;
        chkOn = 1;
    endtask

    task automatic test_single_change();
        apply_reset();
        out_ready = 1;
        in_valid = 2'b01;
        in_irp = '0;
        repeat (3) tick();
        compared++;
        if (dValid[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL no_change_idle: got valid %b required 0", dValid[0]);
        end
        in_irp[9:0] = 10'h001;
        tick();
        compared++;
        if (dValid[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL latency_early: got valid %b required 0", dValid[0]);
        end
        tick();
        compared++;
        if ({dValid[0], dIrp[0], dCore[0], dSeq[0]} !== {1'b1, 10'h001, 8'h00, 16'h0000}) begin
            mismatched++;
            $display("FAIL first_event: got %h required %h", {dValid[0], dIrp[0], dCore[0], dSeq[0]},
                     {1'b1, 10'h001, 8'h00, 16'h0000});
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            compared++;
            if (dValid[0] !== 1'b0) begin
                mismatched++;
                $display("FAIL repeat_value cycle%0d: got valid %b required 0", c, dValid[0]);
            end
        end
        in_valid = '0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [9:0] eIrp [5] = '{10'h002, 10'h080, 10'h004, 10'h100, 10'h008};
        logic [7:0] eCore [5] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
        apply_reset();
        out_ready = 1;
        in_valid = 2'b11;
        in_irp = {10'h080, 10'h002};
        tick();
        in_valid = '0;
        repeat (4) tick();
        in_valid = 2'b01;
        in_irp = {10'h080, 10'h004};
        tick();
        in_valid = '0;
        repeat (3) tick();
        in_valid = 2'b11;
        in_irp = {10'h100, 10'h008};
        tick();
        in_valid = '0;
        repeat (5) tick();
        compared++;
        if (capQ[0].size() != 5) begin
            mismatched++;
            $display("FAIL rr_count: got %0d events required 5", capQ[0].size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                compared++;
                if ({capQ[0][j].irp, capQ[0][j].coreid, capQ[0][j].seq} !== {eIrp[j], eCore[j], 32'(j)}) begin
                    mismatched++;
                    $display("FAIL rr_order ev%0d: got irp %h core %0d seq %0d required irp %h core %0d seq %0d", j,
                             capQ[0][j].irp, capQ[0][j].coreid, capQ[0][j].seq, eIrp[j], eCore[j], j);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 0;
        in_valid = 2'b01;
        for (int k = 0; k < 10; k++) begin
            in_irp[9:0] = 10'(k + 1);
            tick();
        end
        in_valid = '0;
        repeat (2) tick();
        compared++;
        if (lvl0 !== 3'd4) begin
            mismatched++;
            $display("FAIL full_level: got %0d required 4", lvl0);
        end
        compared++;
        if ((coal0 != 16'd0) !== 1'b1) begin
            mismatched++;
            $display("FAIL coalesce_nonzero: got %0d required >0", coal0);
        end
        capQ[0].delete();
        out_ready = 1;
        repeat (8) tick();
        compared++;
        if (capQ[0].size() == 0 || capQ[0][capQ[0].size()-1].irp !== 10'h00A) begin
            mismatched++;
            $display("FAIL last_value: got %0d events last irp %h required last irp 00a", capQ[0].size(),
                     capQ[0].size() ? capQ[0][capQ[0].size()-1].irp : 10'h3FF);
        end
    endtask

    task automatic test_full_mode();
        apply_reset();
        out_ready = 1;
        in_valid = 2'b01;
        in_irp = {10'h000, 10'h3FF};
        repeat (3) tick();
        in_valid = '0;
        repeat (4) tick();
        compared++;
        if (capQ[1].size() != 3) begin
            mismatched++;
            $display("FAIL full_mode_count: got %0d required 3", capQ[1].size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                compared++;
                if ({capQ[1][j].irp, capQ[1][j].coreid, capQ[1][j].seq} !== {10'h3FF, 8'd5, 32'(j)}) begin
                    mismatched++;
                    $display("FAIL full_mode ev%0d: got irp %h core %0d seq %0d required irp 3ff core 5 seq %0d", j,
                             capQ[1][j].irp, capQ[1][j].coreid, capQ[1][j].seq, j);
                end
            end
        end
    endtask

    task automatic test_enable();
        apply_reset();
        out_ready = 1;
        in_valid = 2'b01;
        in_irp = {10'h000, 10'h010};
        repeat (4) tick();
        enable = 0;
        capQ[0].delete();
        in_irp[9:0] = 10'h020;
        repeat (2) tick();
        in_irp[9:0] = 10'h030;
        repeat (2) tick();
        in_irp[9:0] = 10'h010;
        tick();
        enable = 1;
        repeat (4) tick();
        compared++;
        if (capQ[0].size() != 0) begin
            mismatched++;
            $display("FAIL enable_gate: got %0d events required 0", capQ[0].size());
        end
        in_irp[9:0] = 10'h040;
        repeat (4) tick();
        compared++;
        if (capQ[0].size() != 1 || capQ[0][0].irp !== 10'h040) begin
            mismatched++;
            $display("FAIL enable_resume: got %0d events first irp %h required 1 event irp 040", capQ[0].size(),
                     capQ[0].size() ? capQ[0][0].irp : 10'h3FF);
        end
        in_valid = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 0;
        in_valid = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            in_irp[9:0] = 10'(k);
            tick();
        end
        in_valid = '0;
        repeat (3) tick();
        compared++;
        if (lvl0 !== 3'd3) begin
            mismatched++;
            $display("FAIL queued_three: got level %0d required 3", lvl0);
        end
        reset = 1;
        tick();
        for (int d = 0; d < 2; d++) begin
            compared++;
            if ({dValid[d], dLvl[d], dCoal[d]} !== 25'd0) begin
                mismatched++;
                $display("FAIL mid_reset inst%0d: got valid/level/coal %h required 0", d, {dValid[d], dLvl[d], dCoal[d]});
            end
        end
        reset = 0;
        out_ready = 1;
        capQ[0].delete();
        in_valid = 2'b01;
        in_irp[9:0] = 10'h005;
        tick();
        in_valid = '0;
        repeat (3) tick();
        compared++;
        if (capQ[0].size() == 0 || {capQ[0][0].irp, capQ[0][0].seq} !== {10'h005, 32'd0}) begin
            mismatched++;
            $display("FAIL post_reset_seq: got %0d events first seq %0d required irp 005 seq 0", capQ[0].size(),
                     capQ[0].size() ? capQ[0][0].seq : 32'hFFFF);
        end
    endtask

    task automatic test_random();
        logic [9:0] pool [4] = '{10'h000, 10'h001, 10'h002, 10'h3FF};
        int pct [4] = '{90, 30, 100, 10};
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid = NC'($urandom_range(0, 3));
            for (int i = 0; i < NC; i++) in_irp[i*10 +: 10] = pool[$urandom_range(0, 3)];
            out_ready = $urandom_range(0, 99) < pct[(c / 50) % 4];
            enable = $urandom_range(0, 7) != 0;
            tick();
        end
        in_valid = '0;
        enable = 1;
        out_ready = 1;
        repeat (14) tick();
    endtask

    initial begin
        test_reset();
        test_single_change();
        test_simultaneous();
        test_backpressure();
        test_full_mode();
        test_enable();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
